// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
// Produces the per-stage stall vector, sequences exception entry and
// ERET return as FLUSH -> DRAIN, holds EPC / exception level, and
// raises a sticky flag when the pipeline stays stalled too long.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          MAX_STALL    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        excp_i,
  input  logic [31:0] excp_pc_i,
  input  logic        eret_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] epc_o,
  output logic        exl_o,
  output logic        stall_timeout
);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0] WD_LIMIT   = 8'(MAX_STALL);

  state_t      state;
  logic [3:0]  drain_cnt;
  logic [7:0]  wd_cnt;
  logic [8:0]  wd_inc;
  logic [7:0]  wd_sat;
  logic [5:0]  req_stall;

  // Stall request priority: an EX hold must also freeze ID and earlier.
  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_ex)      req_stall = 6'b001111;
    else if (stallreq_id) req_stall = 6'b000111;
  end

  // Watchdog next value, saturating at the 8-bit maximum.
  always_comb begin
    wd_inc = {1'b0, wd_cnt} + 9'd1;
    wd_sat = wd_inc[8] ? 8'hFF : wd_inc[7:0];
  end

  // Stall vector by state: requests only honoured in IDLE; DRAIN holds PC/IF.
  always_comb begin
    stall = 6'b000000;
    case (state)
      IDLE:    stall = req_stall;
      DRAIN:   stall = 6'b000011;
      default: stall = 6'b000000;
    endcase
  end

  // Controller FSM with registered flush/redirect, EPC/EXL and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      wd_cnt        <= '0;
      flush         <= 1'b0;
      new_pc        <= '0;
      epc_o         <= '0;
      exl_o         <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flush  <= 1'b0;
          new_pc <= '0;
          if (|req_stall) begin
            wd_cnt <= wd_sat;
            if (wd_sat >= WD_LIMIT) stall_timeout <= 1'b1;
          end else begin
            wd_cnt <= '0;
          end
          // Exception wins over a simultaneous ERET; nested entry keeps EPC.
          if (excp_i) begin
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= EXC_VECTOR;
            wd_cnt <= '0;
            if (!exl_o) begin
              epc_o <= excp_pc_i;
              exl_o <= 1'b1;
            end
          end else if (eret_i) begin
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= epc_o;
            exl_o  <= 1'b0;
            wd_cnt <= '0;
          end
        end
        FLUSH: begin
          flush     <= 1'b0;
          new_pc    <= '0;
          drain_cnt <= DRAIN_INIT;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) state <= IDLE;
          else                   drain_cnt <= drain_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: random and directed stimulus
// against a cycle-indexed reference model of the controller rules.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h0000_0040;
  localparam int          DRAIN   = 2;
  localparam int          MAXS    = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, excp_i, eret_i;
  logic [31:0] excp_pc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, epc_o;
  logic        exl_o, stall_timeout;

  int n_chk = 0;
  int n_fail = 0;

  pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .DRAIN_CYCLES(DRAIN), .MAX_STALL(MAXS)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .excp_i(excp_i), .excp_pc_i(excp_pc_i), .eret_i(eret_i),
    .stall(stall), .flush(flush), .new_pc(new_pc), .epc_o(epc_o),
    .exl_o(exl_o), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: absolute cycle numbers of the scheduled redirect.
  int          cyc = 0;
  int          flush_cyc = -10;
  int          busy_until = -10;
  logic [31:0] m_epc = '0, m_npc = '0;
  logic        m_exl = 1'b0, m_tmo = 1'b0;
  int          run = 0;

  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_npc;

  task automatic run_cycle();
    @(negedge clk);
    e_flush = 1'b0;
    e_npc   = '0;
    if (cyc == flush_cyc) begin
      e_stall = 6'd0; e_flush = 1'b1; e_npc = m_npc;
    end else if (cyc <= busy_until) begin
      e_stall = 6'b000011;
    end else begin
      e_stall = stallreq_ex ? 6'b001111 : (stallreq_id ? 6'b000111 : 6'd0);
    end
  endtask

  task automatic accept(input logic [31:0] target);
    m_npc      = target;
    flush_cyc  = cyc + 1;
    busy_until = cyc + 1 + DRAIN;
    run        = 0;
  endtask

  task automatic next();
    if (rst) begin
      flush_cyc = -10; busy_until = -10;
      m_epc = '0; m_exl = 1'b0; m_tmo = 1'b0; run = 0;
    end else if (cyc > busy_until) begin
      if (stallreq_ex || stallreq_id) begin
        run = (run < 255) ? run + 1 : 255;
        if (run >= MAXS) m_tmo = 1'b1;
      end else begin
        run = 0;
      end
      if (excp_i) begin
        if (!m_exl) begin m_epc = excp_pc_i; m_exl = 1'b1; end
        accept(EXC_VEC);
      end else if (eret_i) begin
        accept(m_epc);
        m_exl = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    stallreq_id = 0; stallreq_ex = 0; excp_i = 0; eret_i = 0; excp_pc_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in();
    next(); next();
    rst = 1'b0;
    run_cycle();
    n_chk++;
    if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'd0 || epc_o !== 32'd0 ||
        exl_o !== 1'b0 || stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: stall=%b flush=%b new_pc=%h epc=%h exl=%b tmo=%b, want all 0",
               stall, flush, new_pc, epc_o, exl_o, stall_timeout);
    end
    next();
  endtask

  task automatic test_stall_id();
    for (int i = 0; i < 5; i++) begin
      stallreq_id = (i < 3);
      run_cycle();
      n_chk++;
      if (stall !== e_stall || stall !== (i < 3 ? 6'b000111 : 6'b000000) || flush !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_id[%0d]: stall=%b flush=%b want stall=%b flush=0", i, stall, flush, e_stall);
      end
      next();
    end
    idle_in();
  endtask

  task automatic test_stall_both();
    stallreq_id = 1; stallreq_ex = 1;
    run_cycle();
    n_chk++;
    if (stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL stall_both: stall=%b want 001111", stall);
    end
    next();
    stallreq_id = 0;
    run_cycle();
    n_chk++;
    if (stall !== 6'b001111) begin
      n_fail++;
      $display("FAIL stall_ex_only: stall=%b want 001111", stall);
    end
    next();
    idle_in();
  endtask

  // Pulse an event, then follow flush/drain/idle cycle by cycle.
  task automatic event_seq(input string nm, input logic ex, input logic er,
                           input logic [31:0] pc, input logic [31:0] want_npc);
    excp_i = ex; eret_i = er; excp_pc_i = pc;
    run_cycle(); next();
    idle_in();
    stallreq_id = 1'b1;  // must be ignored during flush/drain
    for (int i = 1; i <= DRAIN + 2; i++) begin
      run_cycle();
      n_chk++;
      if (stall !== e_stall || flush !== e_flush || new_pc !== e_npc ||
          (i == 1 && (flush !== 1'b1 || new_pc !== want_npc)) ||
          (i > 1 && i <= DRAIN + 1 && stall !== 6'b000011)) begin
        n_fail++;
        $display("FAIL %s[N+%0d]: stall=%b flush=%b new_pc=%h want stall=%b flush=%b new_pc=%h",
                 nm, i, stall, flush, new_pc, e_stall, e_flush, e_npc);
      end
      next();
    end
    idle_in();
  endtask

  task automatic test_exception();
    event_seq("excp", 1'b1, 1'b0, 32'h100, EXC_VEC);
    run_cycle();
    n_chk++;
    if (epc_o !== 32'h100 || exl_o !== 1'b1) begin
      n_fail++;
      $display("FAIL excp_state: epc=%h exl=%b want epc=00000100 exl=1", epc_o, exl_o);
    end
    next();
  endtask

  task automatic test_nested_eret();
    event_seq("nested", 1'b1, 1'b0, 32'h44, EXC_VEC);
    run_cycle();
    n_chk++;
    if (epc_o !== 32'h100 || exl_o !== 1'b1) begin
      n_fail++;
      $display("FAIL nested_state: epc=%h exl=%b want epc=00000100 exl=1", epc_o, exl_o);
    end
    next();
    event_seq("eret", 1'b0, 1'b1, 32'h0, 32'h100);
    run_cycle();
    n_chk++;
    if (exl_o !== 1'b0 || epc_o !== 32'h100) begin
      n_fail++;
      $display("FAIL eret_state: epc=%h exl=%b want epc=00000100 exl=0", epc_o, exl_o);
    end
    next();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stallreq_id = ($urandom_range(0, 2) == 0);
      stallreq_ex = ($urandom_range(0, 3) == 0);
      excp_i      = ($urandom_range(0, 9) == 0);
      eret_i      = ($urandom_range(0, 9) == 0);
      excp_pc_i   = $urandom & 32'hFFFF_FFFC;
      run_cycle();
      n_chk++;
      if (stall !== e_stall || flush !== e_flush || new_pc !== e_npc || epc_o !== m_epc ||
          exl_o !== m_exl || stall_timeout !== m_tmo) begin
        n_fail++;
        $display("FAIL random[%0d]: stall=%b/%b flush=%b/%b npc=%h/%h epc=%h/%h exl=%b/%b tmo=%b/%b (got/want)",
                 i, stall, e_stall, flush, e_flush, new_pc, e_npc, epc_o, m_epc,
                 exl_o, m_exl, stall_timeout, m_tmo);
      end
      next();
    end
    idle_in();
    for (int i = 0; i < DRAIN + 3; i++) begin run_cycle(); next(); end
  endtask

  task automatic test_timeout();
    stallreq_ex = 1'b1;
    for (int i = 1; i <= MAXS + 5; i++) begin
      run_cycle();
      if (i == MAXS || i == MAXS + 1 || i == MAXS + 5) begin
        n_chk++;
        if (stall_timeout !== m_tmo || stall_timeout !== (i > MAXS)) begin
          n_fail++;
          $display("FAIL timeout[%0d]: tmo=%b want %b", i, stall_timeout, (i > MAXS));
        end
      end
      next();
    end
    idle_in();
    for (int i = 0; i < 3; i++) begin run_cycle(); next(); end
    run_cycle();
    n_chk++;
    if (stall_timeout !== 1'b1 || stall !== 6'd0) begin
      n_fail++;
      $display("FAIL timeout_sticky: tmo=%b stall=%b want tmo=1 stall=000000", stall_timeout, stall);
    end
    rst = 1'b1; next(); rst = 1'b0;
    run_cycle();
    n_chk++;
    if (stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: tmo=%b want 0", stall_timeout);
    end
    next();
  endtask

  task automatic test_reset_drain();
    excp_i = 1'b1; excp_pc_i = 32'h200;
    run_cycle(); next();
    idle_in();
    run_cycle(); next();           // FLUSH
    rst = 1'b1;
    run_cycle(); next();           // first DRAIN cycle, reset sampled here
    rst = 1'b0;
    run_cycle();
    n_chk++;
    if (stall !== 6'd0 || flush !== 1'b0 || new_pc !== 32'd0 || epc_o !== 32'd0 || exl_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain: stall=%b flush=%b npc=%h epc=%h exl=%b want all 0",
               stall, flush, new_pc, epc_o, exl_o);
    end
    next();
    event_seq("excp_eret", 1'b1, 1'b1, 32'h300, EXC_VEC);
    run_cycle();
    n_chk++;
    if (exl_o !== 1'b1 || epc_o !== 32'h300) begin
      n_fail++;
      $display("FAIL excp_eret_state: epc=%h exl=%b want epc=00000300 exl=1", epc_o, exl_o);
    end
    next();
  endtask

  initial begin
    rst = 1'b1; idle_in();
    test_reset();
    test_stall_id();
    test_stall_both();
    test_exception();
    test_nested_eret();
    test_random();
    test_timeout();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
